// File: rtl/duty_cycle_calc_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : duty_cycle_calc_pkg
// Description : Shared definitions for the duty-cycle calculator: FSM state
//               encoding, full-scale value, phase cycle counts, clamp value
//               and the BCD add-3 helper used by the double-dabble stage.
// Revision    : 1.0 - initial release
// ============================================================================
package duty_cycle_calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DIV  = 3'd2,
        ST_BCD  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int unsigned c_SCALE      = 1000;
    // Dividend width: a 32-bit count times 1000 needs 42 bits; one quotient
    // bit is produced per cycle, so the divide phase is also 42 cycles.
    localparam int unsigned c_NUM_W      = 42;
    localparam int unsigned c_DIV_CYCLES = 42;
    localparam int unsigned c_BCD_CYCLES = 10;
    localparam logic [9:0]  c_CLAMP_VAL  = 10'd1000;

    // Add 3 to every BCD digit that is 5 or more, ahead of a left shift.
    function automatic logic [15:0] bcd_add3(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/duty_cycle_calc_divider.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : seq_divider
// Description : Restoring divider, one quotient bit per cycle, MSB first.
//               The quotient is truncated and held until the next start.
// Ports       : sys_clk, rst  - clock, synchronous active-high reset
//               start         - load num/den and begin dividing
//               num, den      - dividend / divisor
//               quotient      - result (valid from the edge after done)
//               done          - high during the cycle of the last step
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import duty_cycle_calc_pkg::*;
#(
    parameter int NUM_W = c_NUM_W,
    parameter int DEN_W = 33
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic [NUM_W-1:0] quotient,
    output logic             done
);

    localparam int CW = $clog2(NUM_W);

    // Dividend bits shift out of the top while quotient bits enter the bottom.
    logic [NUM_W-1:0] r_num_sh;
    logic [DEN_W-1:0] r_rem;
    logic [DEN_W-1:0] r_den;
    logic [CW-1:0]    r_cnt;
    logic             r_run;

    logic [DEN_W:0]   w_trial;
    logic             w_ge;

    assign w_trial  = {r_rem, r_num_sh[NUM_W-1]};
    assign w_ge     = (w_trial >= {1'b0, r_den});
    assign done     = r_run && (r_cnt == CW'(NUM_W-1));
    assign quotient = r_num_sh;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_num_sh <= '0;
            r_rem    <= '0;
            r_den    <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (start) begin
            r_num_sh <= num;
            r_rem    <= '0;
            r_den    <= den;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            // The partial remainder is always below den, so it fits DEN_W bits.
            r_rem    <= DEN_W'(w_ge ? (w_trial - {1'b0, r_den}) : w_trial);
            r_num_sh <= {r_num_sh[NUM_W-2:0], w_ge};
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/duty_cycle_calc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : duty_cycle_calc
// Description : Converts held high/low counts into a per-mille duty cycle
//               (binary and 4-digit BCD). A change of either input starts
//               LOAD -> DIV (42) -> BCD (10) -> DONE; changes seen while busy
//               collapse into one pending recomputation.
// Ports       : sys_clk, rst                 - clock, sync active-high reset
//               sig_in_high_cnt_buf/low      - held counts from the meter
//               duty_permille, duty_bcd      - last result, 0..1000
//               duty_valid                   - one-cycle update pulse
//               busy                         - computation in progress
//               div_zero                     - last result had high+low == 0
// Revision    : 1.0 - initial release
// ============================================================================
module duty_cycle_calc
    import duty_cycle_calc_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int SCALE     = c_SCALE
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] sig_in_high_cnt_buf,
    input  logic [CNT_WIDTH-1:0] sig_in_low_cnt_buf,
    output logic [9:0]           duty_permille,
    output logic [15:0]          duty_bcd,
    output logic                 duty_valid,
    output logic                 busy,
    output logic                 div_zero
);

    localparam int NUM_W = c_NUM_W;
    localparam int DEN_W = CNT_WIDTH + 1;

    state_t               r_state;
    state_t               w_next;

    logic [CNT_WIDTH-1:0] r_high_q;
    logic [CNT_WIDTH-1:0] r_low_q;
    logic [CNT_WIDTH-1:0] r_last_high;
    logic [CNT_WIDTH-1:0] r_last_low;
    logic                 r_pending;
    logic                 r_den_zero;
    logic [3:0]           r_bcd_cnt;
    logic [9:0]           r_bin;
    logic [15:0]          r_bcd;
    logic [9:0]           r_q10;
    logic [9:0]           r_duty_permille;
    logic [15:0]          r_duty_bcd;
    logic                 r_duty_valid;
    logic                 r_div_zero;

    logic                 w_change;
    logic                 w_start;
    logic [NUM_W-1:0]     w_num;
    logic [DEN_W-1:0]     w_den;
    logic [NUM_W-1:0]     w_quot;
    logic                 w_div_done;
    logic [9:0]           w_q_clamped;
    logic                 w_bcd_first;
    logic [9:0]           w_bin_src;
    logic [15:0]          w_bcd_src;
    logic [25:0]          w_shift;

    assign w_change = (r_high_q != r_last_high) || (r_low_q != r_last_low);
    assign w_num    = NUM_W'(r_high_q) * NUM_W'(SCALE);
    assign w_den    = {1'b0, r_high_q} + {1'b0, r_low_q};

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) u_div (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .start    (w_start),
        .num      (w_num),
        .den      (w_den),
        .quotient (w_quot),
        .done     (w_div_done)
    );

    // A zero denominator leaves an all-ones quotient in the divider; force 0.
    always_comb begin
        w_q_clamped = w_quot[9:0];
        if (r_den_zero) begin
            w_q_clamped = '0;
        end else if (w_quot > NUM_W'(c_CLAMP_VAL)) begin
            w_q_clamped = c_CLAMP_VAL;
        end
    end

    // Double dabble: the first BCD cycle seeds from the fresh quotient.
    assign w_bcd_first = (r_bcd_cnt == 4'd0);
    assign w_bin_src   = w_bcd_first ? w_q_clamped : r_bin;
    assign w_bcd_src   = w_bcd_first ? 16'h0000    : r_bcd;
    assign w_shift     = {bcd_add3(w_bcd_src), w_bin_src} << 1;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_change) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_start = 1'b1;
                w_next  = ST_DIV;
            end
            ST_DIV: begin
                if (w_div_done) w_next = ST_BCD;
            end
            ST_BCD: begin
                if (r_bcd_cnt == 4'(c_BCD_CYCLES - 1)) w_next = ST_DONE;
            end
            ST_DONE: begin
                // Skip IDLE when a change is waiting: restart from latest inputs.
                w_next = (r_pending || w_change) ? ST_LOAD : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_high_q        <= '0;
            r_low_q         <= '0;
            r_last_high     <= '0;
            r_last_low      <= '0;
            r_pending       <= 1'b0;
            r_den_zero      <= 1'b0;
            r_bcd_cnt       <= '0;
            r_bin           <= '0;
            r_bcd           <= '0;
            r_q10           <= '0;
            r_duty_permille <= '0;
            r_duty_bcd      <= '0;
            r_duty_valid    <= 1'b0;
            r_div_zero      <= 1'b0;
        end else begin
            r_high_q     <= sig_in_high_cnt_buf;
            r_low_q      <= sig_in_low_cnt_buf;
            r_state      <= w_next;
            r_duty_valid <= (r_state == ST_DONE);

            case (r_state)
                ST_LOAD: begin
                    r_last_high <= r_high_q;
                    r_last_low  <= r_low_q;
                    r_pending   <= 1'b0;
                    r_den_zero  <= (w_den == '0);
                    r_bcd_cnt   <= '0;
                end
                ST_DIV: begin
                    if (w_change) r_pending <= 1'b1;
                end
                ST_BCD: begin
                    if (w_change) r_pending <= 1'b1;
                    if (w_bcd_first) r_q10 <= w_q_clamped;
                    r_bcd     <= w_shift[25:10];
                    r_bin     <= w_shift[9:0];
                    r_bcd_cnt <= r_bcd_cnt + 4'd1;
                end
                ST_DONE: begin
                    if (w_change) r_pending <= 1'b1;
                    r_duty_permille <= r_q10;
                    r_duty_bcd      <= r_bcd;
                    r_div_zero      <= r_den_zero;
                    r_bcd_cnt       <= '0;
                end
                default: begin
                    r_bcd_cnt <= '0;
                end
            endcase
        end
    end

    assign duty_permille = r_duty_permille;
    assign duty_bcd      = r_duty_bcd;
    assign duty_valid    = r_duty_valid;
    assign div_zero      = r_div_zero;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_duty_cycle_calc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_duty_cycle_calc
// Description : Self-checking bench for duty_cycle_calc: fixed vector table,
//               random vectors against an arithmetic reference model, and
//               hand-written sequences for busy-time changes and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_duty_cycle_calc;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [9:0]  duty_permille;
    logic [15:0] duty_bcd;
    logic        duty_valid;
    logic        busy;
    logic        div_zero;

    int n_pass  = 0;
    int n_total = 0;

    always #5 sys_clk = ~sys_clk;

    duty_cycle_calc #(
        .CNT_WIDTH (32),
        .SCALE     (1000)
    ) dut (
        .sys_clk             (sys_clk),
        .rst                 (rst),
        .sig_in_high_cnt_buf (hi),
        .sig_in_low_cnt_buf  (lo),
        .duty_permille       (duty_permille),
        .duty_bcd            (duty_bcd),
        .duty_valid          (duty_valid),
        .busy                (busy),
        .div_zero            (div_zero)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          pm;
        logic [15:0] bcd;
        bit          dz;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference: truncated per-mille ratio, clamped, with decimal digits.
    function automatic void model(input logic [31:0] h, input logic [31:0] l,
                                  output int pm, output logic [15:0] bcd, output bit dz);
        longint unsigned hh, ll, den, q;
        hh = h;
        ll = l;
        den = hh + ll;
        if (den == 0) begin
            pm = 0;
            dz = 1'b1;
        end else begin
            q = (hh * 1000) / den;
            if (q > 1000) q = 1000;
            pm = int'(q);
            dz = 1'b0;
        end
        bcd = {4'(pm / 1000), 4'((pm / 100) % 10), 4'((pm / 10) % 10), 4'(pm % 10)};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_pulse(input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (duty_valid) begin
                k = i;
                break;
            end
        end
    endtask

    // Called #1 after an edge; the next edge registers the new inputs.
    task automatic run_case(input string tag, input logic [31:0] h, input logic [31:0] l,
                            input int pm, input logic [15:0] bcd, input bit dz);
        int k;
        hi = h;
        lo = l;
        @(posedge sys_clk);
        wait_pulse(200, k);
        chk({tag, "_latency"}, k, 55);
        if (k > 0) begin
            chk({tag, "_permille"}, duty_permille, pm);
            chk({tag, "_bcd"}, duty_bcd, bcd);
            chk({tag, "_div_zero"}, div_zero, dz);
            tick();
            chk({tag, "_pulse_width"}, duty_valid, 0);
            chk({tag, "_idle"}, busy, 0);
            repeat (3) tick();
            chk({tag, "_hold"}, duty_permille, pm);
        end
    endtask

    initial begin
        logic [31:0] rh, rl, ph, pl;
        int          mpm;
        logic [15:0] mbcd;
        bit          mdz;
        int          k, npulse, first_k, second_k, pm1, pm2;
        logic [15:0] bcd2;

        vecs[0] = '{32'd25,         32'd75,         250,  16'h0250, 1'b0};
        vecs[1] = '{32'd1,          32'd2,          333,  16'h0333, 1'b0};
        vecs[2] = '{32'd2,          32'd1,          666,  16'h0666, 1'b0};
        vecs[3] = '{32'd100,        32'd0,          1000, 16'h1000, 1'b0};
        vecs[4] = '{32'd0,          32'd0,          0,    16'h0000, 1'b1};
        vecs[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   500,  16'h0500, 1'b0};

        rst = 1'b1;
        hi  = 32'd0;
        lo  = 32'd0;
        repeat (3) tick();
        chk("rst_permille", duty_permille, 0);
        chk("rst_bcd", duty_bcd, 0);
        chk("rst_valid", duty_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_zero", div_zero, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("zero_inputs_no_start", busy, 0);

        foreach (vecs[i]) begin
            run_case($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo,
                     vecs[i].pm, vecs[i].bcd, vecs[i].dz);
        end

        ph = vecs[5].hi;
        pl = vecs[5].lo;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 2))
                0:       begin rh = $urandom;                  rl = $urandom;                  end
                1:       begin rh = $urandom_range(4, 60);     rl = $urandom_range(4, 60);     end
                default: begin rh = $urandom_range(0, 100);    rl = $urandom;                  end
            endcase
            if (rh == ph && rl == pl) rl = rl + 32'd1;
            model(rh, rl, mpm, mbcd, mdz);
            run_case($sformatf("rnd%0d", i), rh, rl, mpm, mbcd, mdz);
            ph = rh;
            pl = rl;
        end

        run_case("pre_seq", 32'd3, 32'd1, 750, 16'h0750, 1'b0);

        // Two changes during one computation collapse into one restart.
        npulse = 0; first_k = -1; second_k = -1; pm1 = -1; pm2 = -1; bcd2 = '0;
        hi = 32'd10;
        lo = 32'd30;
        @(posedge sys_clk);
        for (int kk = 1; kk <= 200; kk++) begin
            tick();
            if (kk == 9)  begin hi = 32'd7;  lo = 32'd7;  end
            if (kk == 19) begin hi = 32'd30; lo = 32'd10; end
            if (kk == 20) chk("seq_busy_mid", busy, 1);
            if (duty_valid) begin
                npulse++;
                if (npulse == 1) begin
                    first_k = kk;
                    pm1 = duty_permille;
                end else if (npulse == 2) begin
                    second_k = kk;
                    pm2 = duty_permille;
                    bcd2 = duty_bcd;
                end
            end
        end
        chk("seq_first_latency", first_k, 55);
        chk("seq_first_permille", pm1, 250);
        chk("seq_second_latency", second_k, 109);
        chk("seq_second_permille", pm2, 750);
        chk("seq_second_bcd", bcd2, 16'h0750);
        chk("seq_pulse_count", npulse, 2);

        // Reset 30 edges into a computation, then recompute the same inputs.
        npulse = 0;
        hi = 32'd40;
        lo = 32'd60;
        @(posedge sys_clk);
        for (int kk = 1; kk <= 29; kk++) begin
            tick();
            if (duty_valid) npulse++;
        end
        chk("abort_prior_hold", duty_permille, 750);
        rst = 1'b1;
        tick();
        chk("abort_permille", duty_permille, 0);
        chk("abort_bcd", duty_bcd, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", duty_valid, 0);
        chk("abort_div_zero", div_zero, 0);
        rst = 1'b0;
        @(posedge sys_clk);
        wait_pulse(200, k);
        chk("abort_no_early_pulse", npulse, 0);
        chk("recompute_latency", k, 55);
        chk("recompute_permille", duty_permille, 400);
        chk("recompute_bcd", duty_bcd, 16'h0400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
